// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder: one load/store in flight, response LATENCY+1 cycles after accept.
// Backpressure: RESP holds outputs until resp_ready; req_ready is high only while IDLE.
module dmem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CW    = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [1:0]            size;
    logic                  uns;
  } req_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt;
  req_t                  r;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-3:0]   idx;
  logic [1:0]              lane;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rword, shifted, ld, wsrc, wnew;
  logic [DATA_WIDTH/8-1:0] be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      r          <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (req_valid) begin
          r   <= '{req_write, req_addr, req_wdata, req_size, req_unsigned};
          cnt <= CW'(LATENCY - 1);
        end
        S_WAIT: cnt <= cnt - CW'(1);
        S_EXEC: begin
          resp_err   <= err;
          resp_rdata <= (err || r.write) ? '0 : ld;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = (LATENCY == 1) ? S_EXEC : S_WAIT;
      S_WAIT:  if (cnt <= CW'(1)) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_RESP;
      S_RESP:  if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);

  // Access datapath works on the latched request; only EXEC consumes it.
  assign idx  = r.addr[ADDR_WIDTH-1:2];
  assign lane = r.addr[1:0];
  assign err  = (r.size == 2'b11) ||
                (r.size == 2'b01 && lane[0]) ||
                (r.size == 2'b10 && lane != 2'b00);

  assign rword   = mem[idx];
  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    ld   = shifted;
    be   = '1;
    wsrc = r.wdata;
    case (r.size)
      2'b00: begin
        ld   = r.uns ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                     : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
        be   = (DATA_WIDTH/8)'(1) << lane;
        wsrc = {(DATA_WIDTH/8){r.wdata[7:0]}};
      end
      2'b01: begin
        ld   = r.uns ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                     : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
        be   = lane[1] ? (DATA_WIDTH/8)'(4'b1100) : (DATA_WIDTH/8)'(4'b0011);
        wsrc = {(DATA_WIDTH/16){r.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    wnew = rword;
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (be[i]) wnew[8*i +: 8] = wsrc[8*i +: 8];
  end

  // Array has no reset; reset forces IDLE so a store still waiting never lands.
  always_ff @(posedge clk) begin
    if (state == S_EXEC && r.write && !err)
      mem[idx] <= wnew;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 1, 4) behind one request/response driver.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        resp_ready = 1'b0;
  logic        req_write = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;

  logic        rdy2, vld2, err2, rdy1, vld1, err1, rdy4, vld4, err4;
  logic [31:0] rd2, rd1, rd4;
  logic        rdy_m, vld_m, err_m;
  logic [31:0] rd_m;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 0), .req_ready(rdy2),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld2), .resp_ready(resp_ready && sel == 0),
    .resp_rdata(rd2), .resp_err(err2));

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 1), .req_ready(rdy1),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld1), .resp_ready(resp_ready && sel == 1),
    .resp_rdata(rd1), .resp_err(err1));

  dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2), .req_ready(rdy4),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned), .resp_valid(vld4), .resp_ready(resp_ready && sel == 2),
    .resp_rdata(rd4), .resp_err(err4));

  always_comb begin
    rdy_m = rdy2; vld_m = vld2; err_m = err2; rd_m = rd2;
    if (sel == 1) begin rdy_m = rdy1; vld_m = vld1; err_m = err1; rd_m = rd1; end
    if (sel == 2) begin rdy_m = rdy4; vld_m = vld4; err_m = err4; rd_m = rd4; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic w, input logic [9:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic u);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d; req_size = s; req_unsigned = u;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !rdy_m; i++) @(negedge clk);
    check("accept_ready", 32'(rdy_m), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Cycles after the accept cycle up to and including the first resp_valid cycle.
  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (vld_m) break;
    end
  endtask

  task automatic take_resp;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic u, input int exp_lat,
                      input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    start_req(w, a, d, s, u);
    wait_resp(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd_m, exp_rd);
    check({tag, "_err"}, 32'(err_m), 32'(exp_err));
    take_resp();
  endtask

  initial begin
    int lat;
    #12;
    check("rst_valid", 32'(vld_m), 32'd0);
    check("rst_ready", 32'(rdy_m), 32'd1);
    check("rst_rdata", rd_m, 32'd0);
    check("rst_err", 32'(err_m), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Reset during WAIT drops the pending store.
    xfer("pre_st", 1'b1, 10'h010, 32'h0BADF00D, 2'b10, 1'b0, 3, 32'h0, 1'b0);
    start_req(1'b1, 10'h010, 32'hDEADBEEF, 2'b10, 1'b0);
    @(negedge clk);
    check("wait_ready", 32'(rdy_m), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(vld_m), 32'd0);
    check("midrst_ready", 32'(rdy_m), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    xfer("rst_ld", 1'b0, 10'h010, 32'h0, 2'b10, 1'b0, 3, 32'h0BADF00D, 1'b0);

    xfer("sw20", 1'b1, 10'h020, 32'h12345678, 2'b10, 1'b0, 3, 32'h0, 1'b0);
    xfer("lw20", 1'b0, 10'h020, 32'h0, 2'b10, 1'b0, 3, 32'h12345678, 1'b0);

    xfer("sw40", 1'b1, 10'h040, 32'h80FF7F01, 2'b10, 1'b0, 3, 32'h0, 1'b0);
    xfer("lb43", 1'b0, 10'h043, 32'h0, 2'b00, 1'b0, 3, 32'hFFFFFF80, 1'b0);
    xfer("lbu43", 1'b0, 10'h043, 32'h0, 2'b00, 1'b1, 3, 32'h00000080, 1'b0);
    xfer("lh42", 1'b0, 10'h042, 32'h0, 2'b01, 1'b0, 3, 32'hFFFF80FF, 1'b0);
    xfer("lhu40", 1'b0, 10'h040, 32'h0, 2'b01, 1'b1, 3, 32'h00007F01, 1'b0);

    xfer("sw40b", 1'b1, 10'h040, 32'h11223344, 2'b10, 1'b0, 3, 32'h0, 1'b0);
    xfer("sb41", 1'b1, 10'h041, 32'h555555AA, 2'b00, 1'b0, 3, 32'h0, 1'b0);
    xfer("lw_sb", 1'b0, 10'h040, 32'h0, 2'b10, 1'b0, 3, 32'h1122AA44, 1'b0);
    xfer("sh42", 1'b1, 10'h042, 32'h1234BEEF, 2'b01, 1'b0, 3, 32'h0, 1'b0);
    xfer("lw_sh", 1'b0, 10'h040, 32'h0, 2'b10, 1'b0, 3, 32'hBEEFAA44, 1'b0);

    xfer("lw22", 1'b0, 10'h022, 32'h0, 2'b10, 1'b0, 3, 32'h0, 1'b1);
    xfer("sh45", 1'b1, 10'h045, 32'hFFFFFFFF, 2'b01, 1'b0, 3, 32'h0, 1'b1);
    xfer("sz11", 1'b1, 10'h040, 32'h00000000, 2'b11, 1'b0, 3, 32'h0, 1'b1);
    xfer("sw22", 1'b1, 10'h022, 32'hA5A5A5A5, 2'b10, 1'b0, 3, 32'h0, 1'b1);
    xfer("rb40", 1'b0, 10'h040, 32'h0, 2'b10, 1'b0, 3, 32'hBEEFAA44, 1'b0);
    xfer("rb20", 1'b0, 10'h020, 32'h0, 2'b10, 1'b0, 3, 32'h12345678, 1'b0);

    // Response held under backpressure for five cycles.
    start_req(1'b0, 10'h040, 32'h0, 2'b10, 1'b0);
    wait_resp(lat);
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(vld_m), 32'd1);
      check("bp_rdata", rd_m, 32'hBEEFAA44);
      check("bp_err", 32'(err_m), 32'd0);
      check("bp_ready", 32'(rdy_m), 32'd0);
      @(negedge clk);
    end
    take_resp();
    check("bp_rel_valid", 32'(vld_m), 32'd0);
    check("bp_rel_ready", 32'(rdy_m), 32'd1);

    sel = 1;
    xfer("l1_sw", 1'b1, 10'h080, 32'hCAFEF00D, 2'b10, 1'b0, 2, 32'h0, 1'b0);
    xfer("l1_lw", 1'b0, 10'h080, 32'h0, 2'b10, 1'b0, 2, 32'hCAFEF00D, 1'b0);
    sel = 2;
    xfer("l4_sw", 1'b1, 10'h080, 32'hCAFEF00D, 2'b10, 1'b0, 5, 32'h0, 1'b0);
    xfer("l4_lb", 1'b0, 10'h083, 32'h0, 2'b00, 1'b0, 5, 32'hFFFFFFCA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
